// File: rtl/ss_scan_decoder.sv
// Recovers the four digits shown on a multiplexed active-low seven-segment display.
// Define SS_DEC_TIME_CHECK_EN to enable the HH:MM legality flag on time_err.
module ss_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned TIMEOUT       = 2000000
) (
  input  logic        CLK100MHZ,
  input  logic        reset_n,
  input  logic [3:0]  AN,
  input  logic [6:0]  SEG,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        an_err,
  output logic        stale,
  output logic        time_err
);

  localparam int unsigned     TW          = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      STABLE_M1   = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]      STABLE_SAT  = 8'(STABLE_CYCLES);
  localparam logic [TW-1:0]   TIMEOUT_SAT = TW'(TIMEOUT);
  localparam logic [TW-1:0]   IDLE_ONE    = TW'(1);

  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = 5'h00;
      7'h79:   res = 5'h01;
      7'h24:   res = 5'h02;
      7'h30:   res = 5'h03;
      7'h19:   res = 5'h04;
      7'h12:   res = 5'h05;
      7'h02:   res = 5'h06;
      7'h78:   res = 5'h07;
      7'h00:   res = 5'h08;
      7'h10:   res = 5'h09;
      default: res = 5'h1F;
    endcase
    return res;
  endfunction

  logic [3:0]    an_s1_r, an_s2_r;
  logic [6:0]    seg_s1_r, seg_s2_r;
  logic [7:0]    stable_cnt_r;
  logic [TW-1:0] idle_cnt_r;
  logic [3:0]    mask_r;
  logic [3:0]    slot_r [4];
  logic [15:0]   digits_r;
  logic          frame_valid_r, seg_err_r, an_err_r, stale_r;

  logic          change_s, hit_s, blank_s, one_low_s, complete_s;
  logic [4:0]    dec_s;
  logic [15:0]   frame_s;

  // Qualify the synchronised bus: change detect, one-shot sample strobe, anode class
  always_comb begin
    change_s   = (an_s1_r != an_s2_r) || (seg_s1_r != seg_s2_r);
    hit_s      = !change_s && (stable_cnt_r == STABLE_M1);
    blank_s    = (an_s2_r == 4'b1111);
    case (an_s2_r)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low_s = 1'b1;
      default:                            one_low_s = 1'b0;
    endcase
    complete_s = (mask_r == 4'b1111);
    dec_s      = seg_decode(seg_s2_r);
    frame_s    = {slot_r[3], slot_r[2], slot_r[1], slot_r[0]};
  end

  // Synchronise, time stability, collect slots and publish complete frames
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      an_s1_r       <= 4'b0000;
      an_s2_r       <= 4'b0000;
      seg_s1_r      <= 7'h00;
      seg_s2_r      <= 7'h00;
      stable_cnt_r  <= 8'd0;
      idle_cnt_r    <= {TW{1'b0}};
      mask_r        <= 4'b0000;
      for (int i = 0; i < 4; i++) slot_r[i] <= 4'h0;
      digits_r      <= 16'h0000;
      frame_valid_r <= 1'b0;
      seg_err_r     <= 1'b0;
      an_err_r      <= 1'b0;
      stale_r       <= 1'b1;
    end else begin
      an_s1_r  <= AN;
      an_s2_r  <= an_s1_r;
      seg_s1_r <= SEG;
      seg_s2_r <= seg_s1_r;

      if (change_s)
        stable_cnt_r <= 8'd1;
      else if (stable_cnt_r != STABLE_SAT)
        stable_cnt_r <= stable_cnt_r + 8'd1;
      else
        stable_cnt_r <= stable_cnt_r;

      frame_valid_r <= complete_s;
      seg_err_r     <= 1'b0;
      an_err_r      <= 1'b0;
      if (complete_s) digits_r <= frame_s;

      // A sample landing on the completion cycle seeds the next mask
      if (hit_s && one_low_s) begin
        for (int i = 0; i < 4; i++)
          if (!an_s2_r[i]) slot_r[i] <= dec_s[3:0];
        mask_r     <= (complete_s ? 4'b0000 : mask_r) | ~an_s2_r;
        seg_err_r  <= dec_s[4];
        idle_cnt_r <= {TW{1'b0}};
      end else begin
        if (hit_s && !blank_s) begin
          an_err_r <= 1'b1;
          mask_r   <= 4'b0000;
        end else if (complete_s) begin
          mask_r   <= 4'b0000;
        end
        if (idle_cnt_r != TIMEOUT_SAT) idle_cnt_r <= idle_cnt_r + IDLE_ONE;
      end

      if (complete_s)
        stale_r <= 1'b0;
      else if (idle_cnt_r == TIMEOUT_SAT)
        stale_r <= 1'b1;
      else
        stale_r <= stale_r;
    end
  end

  assign digits      = digits_r;
  assign frame_valid = frame_valid_r;
  assign seg_err     = seg_err_r;
  assign an_err      = an_err_r;
  assign stale       = stale_r;

`ifdef SS_DEC_TIME_CHECK_EN
  logic time_err_r;

  function automatic logic time_illegal(input logic [15:0] d);
    return (d[15:12] > 4'd2) || ((d[15:12] == 4'd2) && (d[11:8] > 4'd3)) ||
           (d[11:8] > 4'd9) || (d[7:4] > 4'd5) || (d[3:0] > 4'd9);
  endfunction

  // Legality is refreshed only when a new frame is published
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n)
      time_err_r <= 1'b0;
    else if (complete_s)
      time_err_r <= time_illegal(frame_s);
    else
      time_err_r <= time_err_r;
  end

  assign time_err = time_err_r;
`else
  assign time_err = 1'b0;
`endif

endmodule
